// File: rtl/burst_cmd_engine.sv
// Splits a linear transfer command into controller bursts of up to BURST_MAX beats, with an outstanding limit.
// Optional: define BOUNDARY_SPLIT_EN to stop bursts from crossing 2^BOUNDARY_BITS-aligned addresses.
module burst_cmd_engine #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH       = 32,
    parameter int BURST_MAX       = 16,
    parameter int ADDR_PER_BEAT   = 8,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int BOUNDARY_BITS   = 12
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [CTRL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    output logic                       cmd_done,
    output logic                       burst_valid,
    input  logic                       burst_ready,
    output logic [CTRL_ADDR_WIDTH-1:0] burst_addr,
    output logic [3:0]                 burst_len,
    output logic [ID_WIDTH-1:0]        burst_id,
    input  logic                       burst_done,
    output logic [3:0]                 outstanding
);

    localparam int BEAT_SHIFT = $clog2(ADDR_PER_BEAT);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                     state;
    logic [CTRL_ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]       remaining;
    logic [4:0]                 nb_q;
    logic [4:0]                 nb_calc;
    logic                       accept;
    logic                       burst_hs;
    logic                       done_eff;

`ifdef BOUNDARY_SPLIT_EN
    localparam int BW = BOUNDARY_BITS + 1;
    localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_MASK = ~CTRL_ADDR_WIDTH'(ADDR_PER_BEAT - 1);
    logic [BW-1:0] beats_to_boundary;
`endif

    // Handshake: a transfer happens in any cycle where valid and ready are both high at the clock edge.
    assign cmd_ready   = (state == S_IDLE) || (state == S_DONE);
    assign accept      = cmd_valid && cmd_ready;
    assign burst_valid = (state == S_ISSUE) && (outstanding < 4'(MAX_OUTSTANDING));
    assign burst_hs    = burst_valid && burst_ready;
    assign done_eff    = burst_done && (outstanding != 4'd0);

    always_comb begin
        nb_calc = (remaining > LEN_WIDTH'(BURST_MAX)) ? 5'(BURST_MAX) : remaining[4:0];
`ifdef BOUNDARY_SPLIT_EN
        beats_to_boundary = ((BW'(1) << BOUNDARY_BITS) - BW'(cur_addr[BOUNDARY_BITS-1:0])) >> BEAT_SHIFT;
        if (beats_to_boundary < BW'(nb_calc)) begin
            nb_calc = beats_to_boundary[4:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            nb_q        <= '0;
            burst_addr  <= '0;
            burst_len   <= '0;
            burst_id    <= '0;
            cmd_done    <= 1'b0;
            outstanding <= '0;
        end else begin
            cmd_done <= 1'b0;
            if (burst_hs && !done_eff) begin
                outstanding <= outstanding + 4'd1;
            end else if (!burst_hs && done_eff) begin
                outstanding <= outstanding - 4'd1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (accept) begin
`ifdef BOUNDARY_SPLIT_EN
                        cur_addr <= cmd_addr & ADDR_MASK;
`else
                        cur_addr <= cmd_addr;
`endif
                        remaining <= cmd_len;
                        // Zero-length commands pass through DRAIN so cmd_done keeps its two-cycle spacing.
                        state <= (cmd_len == '0) ? S_DRAIN : S_CALC;
                    end
                end
                S_CALC: begin
                    nb_q       <= nb_calc;
                    burst_addr <= cur_addr;
                    burst_len  <= 4'(nb_calc - 5'd1);
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (burst_hs) begin
                        cur_addr  <= cur_addr + (CTRL_ADDR_WIDTH'(nb_q) << BEAT_SHIFT);
                        remaining <= remaining - LEN_WIDTH'(nb_q);
                        burst_id  <= burst_id + ID_WIDTH'(1);
                        state     <= (remaining > LEN_WIDTH'(nb_q)) ? S_CALC : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (outstanding == 4'd0) begin
                        state    <= S_DONE;
                        cmd_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_cmd_engine.sv
// Directed testbench for burst_cmd_engine; per-scenario tasks with inline checks against hand-computed values.
// Compile with BOUNDARY_SPLIT_EN to match a DUT built with boundary splitting.
module tb_burst_cmd_engine;
    localparam int CAW = 28;
    localparam int LW  = 32;
    localparam int IW  = 4;

    logic           clk;
    logic           rstn;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [CAW-1:0] cmd_addr;
    logic [LW-1:0]  cmd_len;
    logic           cmd_done;
    logic           burst_valid;
    logic           burst_ready;
    logic [CAW-1:0] burst_addr;
    logic [3:0]     burst_len;
    logic [IW-1:0]  burst_id;
    logic           burst_done;
    logic [3:0]     outstanding;

    int             cyc;
    int             compared;
    int             failed;
    logic [IW-1:0]  exp_id;

    burst_cmd_engine dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_done(cmd_done),
        .burst_valid(burst_valid), .burst_ready(burst_ready), .burst_addr(burst_addr),
        .burst_len(burst_len), .burst_id(burst_id), .burst_done(burst_done),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_cmd(input logic [CAW-1:0] a, input logic [LW-1:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit got = 0;
        burst_ready = 1'b1;
        burst_done  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_done) begin
                got = 1;
                break;
            end
            if (burst_valid) exp_id++;
            step();
        end
        compared++;
        if (!got) begin
            failed++;
            $display("FAIL drain_cmd_done: got no cmd_done within 200 cycles, required a pulse");
        end
        burst_done  = 1'b0;
        burst_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        burst_ready = 1'b0; burst_done = 1'b0; exp_id = '0;
        repeat (3) step();
        compared++;
        if ({cmd_ready, cmd_done, burst_valid, burst_addr, burst_len, burst_id, outstanding}
            !== {1'b1, 1'b0, 1'b0, 28'h0, 4'h0, 4'h0, 4'h0}) begin
            failed++;
            $display("FAIL reset_outputs: got rdy=%0b done=%0b v=%0b a=%0h l=%0d id=%0d o=%0d required 1 0 0 0 0 0 0",
                     cmd_ready, cmd_done, burst_valid, burst_addr, burst_len, burst_id, outstanding);
        end
        rstn = 1'b1;
        step();
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        compared++;
        if (outstanding !== 4'd0) begin
            failed++;
            $display("FAIL stray_done_outstanding: got %0d required 0", outstanding);
        end
        compared++;
        if (cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL idle_cmd_ready: got %0b required 1", cmd_ready);
        end
    endtask

    task automatic test_split();
        logic [CAW-1:0] ea [3];
        logic [3:0]     el [3];
        int due_q[$];
        int acc, nb, nd, last_done;
        ea[0] = 28'h100; ea[1] = 28'h180; ea[2] = 28'h200;
        el[0] = 4'd15;   el[1] = 4'd15;   el[2] = 4'd7;
        nb = 0; nd = 0; last_done = -100;
        burst_ready = 1'b1;
        start_cmd(28'h100, 32'd40);
        acc = cyc - 1;
        for (int i = 0; i < 40; i++) begin
            burst_done = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                burst_done = 1'b1;
                last_done  = cyc;
            end
            if (burst_valid && burst_ready) begin
                if (nb == 0) begin
                    compared++;
                    if (cyc !== acc + 2) begin
                        failed++;
                        $display("FAIL split_first_latency: got %0d cycles required 2", cyc - acc);
                    end
                end
                compared++;
                if (nb >= 3) begin
                    failed++;
                    $display("FAIL split_extra_burst: got burst %0d required only 3", nb);
                end else if ({burst_addr, burst_len, burst_id} !== {ea[nb], el[nb], exp_id}) begin
                    failed++;
                    $display("FAIL split_burst%0d: got a=%0h l=%0d id=%0d required a=%0h l=%0d id=%0d",
                             nb, burst_addr, burst_len, burst_id, ea[nb], el[nb], exp_id);
                end
                due_q.push_back(cyc + 4);
                nb++;
                exp_id++;
            end
            if (cmd_done) begin
                nd++;
                compared++;
                if (cyc !== last_done + 2) begin
                    failed++;
                    $display("FAIL split_done_latency: got %0d cycles required 2", cyc - last_done);
                end
            end
            step();
        end
        burst_done  = 1'b0;
        burst_ready = 1'b0;
        compared++;
        if (nb !== 3 || nd !== 1) begin
            failed++;
            $display("FAIL split_counts: got bursts=%0d dones=%0d required 3 1", nb, nd);
        end
    endtask

    task automatic test_outstanding_limit();
        int hs = 0;
        bit got = 0;
        burst_ready = 1'b1;
        burst_done  = 1'b0;
        start_cmd(28'h0, 32'd64);
        for (int i = 0; i < 12; i++) begin
            if (burst_valid && burst_ready) begin
                hs++;
                exp_id++;
            end
            step();
        end
        compared++;
        if ({hs[3:0], burst_valid, outstanding} !== {4'd2, 1'b0, 4'd2}) begin
            failed++;
            $display("FAIL limit_hold: got hs=%0d v=%0b o=%0d required hs=2 v=0 o=2", hs, burst_valid, outstanding);
        end
        burst_done = 1'b1;
        step();
        burst_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (burst_valid) begin
                got = 1;
                compared++;
                if ({burst_addr, burst_len, burst_id} !== {28'h100, 4'd15, exp_id}) begin
                    failed++;
                    $display("FAIL limit_third: got a=%0h l=%0d id=%0d required a=100 l=15 id=%0d",
                             burst_addr, burst_len, burst_id, exp_id);
                end
                exp_id++;
                step();
                break;
            end
            step();
        end
        compared++;
        if (!got) begin
            failed++;
            $display("FAIL limit_release: got no third burst_valid required one after a done");
        end
        drain();
    endtask

    task automatic test_zero_len();
        start_cmd(28'h40, 32'd0);
        compared++;
        if ({burst_valid, cmd_done, cmd_ready} !== 3'b000) begin
            failed++;
            $display("FAIL zero_cycle1: got v=%0b done=%0b rdy=%0b required 0 0 0", burst_valid, cmd_done, cmd_ready);
        end
        step();
        compared++;
        if ({burst_valid, cmd_done, cmd_ready} !== 3'b011) begin
            failed++;
            $display("FAIL zero_cycle2: got v=%0b done=%0b rdy=%0b required 0 1 1", burst_valid, cmd_done, cmd_ready);
        end
        step();
        compared++;
        if ({burst_valid, cmd_done, cmd_ready} !== 3'b001) begin
            failed++;
            $display("FAIL zero_cycle3: got v=%0b done=%0b rdy=%0b required 0 0 1", burst_valid, cmd_done, cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        bit got = 0;
        burst_ready = 1'b0;
        burst_done  = 1'b0;
        start_cmd(28'h40, 32'd32);
        for (int i = 0; i < 10; i++) begin
            if (burst_valid) begin
                got = 1;
                break;
            end
            step();
        end
        compared++;
        if (!got) begin
            failed++;
            $display("FAIL bp_first_valid: got no burst_valid required one");
        end
        for (int i = 0; i < 5; i++) begin
            step();
            compared++;
            if ({burst_valid, burst_addr, burst_len, burst_id} !== {1'b1, 28'h40, 4'd15, exp_id}) begin
                failed++;
                $display("FAIL bp_stable%0d: got v=%0b a=%0h l=%0d id=%0d required v=1 a=40 l=15 id=%0d",
                         i, burst_valid, burst_addr, burst_len, burst_id, exp_id);
            end
        end
        burst_ready = 1'b1;
        step();
        burst_ready = 1'b0;
        exp_id++;
        compared++;
        if ({outstanding, burst_valid} !== {4'd1, 1'b0}) begin
            failed++;
            $display("FAIL bp_after_hs: got o=%0d v=%0b required o=1 v=0", outstanding, burst_valid);
        end
        step();
        compared++;
        if ({burst_valid, burst_addr, burst_len, burst_id} !== {1'b1, 28'hC0, 4'd15, exp_id}) begin
            failed++;
            $display("FAIL bp_second: got v=%0b a=%0h l=%0d id=%0d required v=1 a=c0 l=15 id=%0d",
                     burst_valid, burst_addr, burst_len, burst_id, exp_id);
        end
        burst_ready = 1'b1;
        burst_done  = 1'b1;
        step();
        burst_ready = 1'b0;
        burst_done  = 1'b0;
        exp_id++;
        compared++;
        if (outstanding !== 4'd1) begin
            failed++;
            $display("FAIL bp_hs_and_done: got o=%0d required 1", outstanding);
        end
        drain();
    endtask

    task automatic test_boundary();
        logic [CAW-1:0] ea [2];
        logic [3:0]     el [2];
        int ne, nb;
`ifdef BOUNDARY_SPLIT_EN
        ne = 2;
        ea[0] = 28'hFC0; el[0] = 4'd7;
        ea[1] = 28'h1000; el[1] = 4'd7;
`else
        ne = 1;
        ea[0] = 28'hFC0; el[0] = 4'd15;
        ea[1] = 28'h0;   el[1] = 4'd0;
`endif
        nb = 0;
        burst_ready = 1'b1;
        burst_done  = 1'b0;
        start_cmd(28'hFC0, 32'd16);
        for (int i = 0; i < 12; i++) begin
            if (burst_valid && burst_ready) begin
                compared++;
                if (nb >= ne) begin
                    failed++;
                    $display("FAIL bound_extra: got burst %0d required only %0d", nb, ne);
                end else if ({burst_addr, burst_len, burst_id} !== {ea[nb], el[nb], exp_id}) begin
                    failed++;
                    $display("FAIL bound_burst%0d: got a=%0h l=%0d id=%0d required a=%0h l=%0d id=%0d",
                             nb, burst_addr, burst_len, burst_id, ea[nb], el[nb], exp_id);
                end
                nb++;
                exp_id++;
            end
            step();
        end
        compared++;
        if (nb !== ne) begin
            failed++;
            $display("FAIL bound_count: got %0d bursts required %0d", nb, ne);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit got = 0;
        burst_ready = 1'b1;
        burst_done  = 1'b0;
        start_cmd(28'h300, 32'd48);
        for (int i = 0; i < 10; i++) begin
            if (burst_valid) break;
            step();
        end
        step();
        rstn = 1'b0;
        step();
        compared++;
        if ({cmd_ready, cmd_done, burst_valid, burst_addr, burst_len, burst_id, outstanding}
            !== {1'b1, 1'b0, 1'b0, 28'h0, 4'h0, 4'h0, 4'h0}) begin
            failed++;
            $display("FAIL midreset_outputs: got rdy=%0b done=%0b v=%0b a=%0h l=%0d id=%0d o=%0d required 1 0 0 0 0 0 0",
                     cmd_ready, cmd_done, burst_valid, burst_addr, burst_len, burst_id, outstanding);
        end
        rstn   = 1'b1;
        exp_id = '0;
        step();
        start_cmd(28'h20, 32'd8);
        for (int i = 0; i < 10; i++) begin
            if (burst_valid) begin
                got = 1;
                compared++;
                if ({burst_addr, burst_len, burst_id} !== {28'h20, 4'd7, 4'd0}) begin
                    failed++;
                    $display("FAIL midreset_restart: got a=%0h l=%0d id=%0d required a=20 l=7 id=0",
                             burst_addr, burst_len, burst_id);
                end
                exp_id++;
                step();
                break;
            end
            step();
        end
        compared++;
        if (!got) begin
            failed++;
            $display("FAIL midreset_no_burst: got no burst_valid after restart required one");
        end
        drain();
    endtask

    initial begin
        cyc = 0; compared = 0; failed = 0;
        test_reset();
        test_split();
        test_outstanding_limit();
        test_zero_len();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
